// File: rtl/ha_array_pkg.sv
// Shared types and sizes for the 8x8 approximate multiplier final-addition stage.
package ha_array_pkg;
    localparam int N_GROUPS    = 4;
    localparam int B_W         = 7;
    localparam int T_W         = 9;
    localparam int OUT_W       = 16;
    localparam int GROUP_SUM_W = 10;
    localparam int SUM_W       = 17;

    typedef logic [GROUP_SUM_W-1:0] group_sum_t;

    typedef struct packed {
        logic [B_W-1:0] b;
        logic [T_W-1:0] t;
    } grp_in_t;
endpackage

// File: rtl/ha_group_weight.sv
// Per-group weighting: carry bits sit two places above the matching sum bits.
module ha_group_weight
    import ha_array_pkg::*;
(
    input  grp_in_t    grp,
    output group_sum_t g
);
    assign g = group_sum_t'(grp.t) + (group_sum_t'(grp.b) << 2);
endmodule

// File: rtl/ha_array_accum.sv
// Two-stage valid/ready accumulator summing the four weighted ha_array groups.
// Define HA_ARRAY_ACCUM_SAT_EN to saturate product to 16'hFFFF on overflow.
module ha_array_accum
    import ha_array_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [B_W-1:0]   ha_array_0_b,
    input  logic [B_W-1:0]   ha_array_1_b,
    input  logic [B_W-1:0]   ha_array_2_b,
    input  logic [B_W-1:0]   ha_array_3_b,
    input  logic [T_W-1:0]   ha_array_0_t,
    input  logic [T_W-1:0]   ha_array_1_t,
    input  logic [T_W-1:0]   ha_array_2_t,
    input  logic [T_W-1:0]   ha_array_3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             ovf
);
    localparam int STAGES = 2;

    logic [STAGES:1]   vld_q;
    logic [STAGES:0]   vld_pipe;
    logic              s1_adv, s2_adv;
    grp_in_t    [N_GROUPS-1:0] grp;
    group_sum_t [N_GROUPS-1:0] g_comb, g_q;
    logic [SUM_W-1:0]  sum;
    logic [OUT_W-1:0]  prod_next;

    assign vld_pipe = {vld_q, in_valid};

    assign grp[0] = '{b: ha_array_0_b, t: ha_array_0_t};
    assign grp[1] = '{b: ha_array_1_b, t: ha_array_1_t};
    assign grp[2] = '{b: ha_array_2_b, t: ha_array_2_t};
    assign grp[3] = '{b: ha_array_3_b, t: ha_array_3_t};

    for (genvar k = 0; k < N_GROUPS; k++) begin : g_weight
        ha_group_weight u_gw (.grp(grp[k]), .g(g_comb[k]));
    end

    // in_ready depends only on state and out_ready, never on in_valid.
    assign s2_adv   = !vld_pipe[2] || out_ready;
    assign s1_adv   = s2_adv || !vld_pipe[1];
    assign in_ready = s1_adv;

    // Group k lands two bit positions above group k-1.
    always_comb begin
        sum = '0;
        for (int k = 0; k < N_GROUPS; k++)
            sum = sum + (SUM_W'(g_q[k]) << (2 * k));
    end

`ifdef HA_ARRAY_ACCUM_SAT_EN
    assign prod_next = sum[SUM_W-1] ? '1 : sum[OUT_W-1:0];
`else
    assign prod_next = sum[OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            g_q     <= '0;
            product <= '0;
            ovf     <= 1'b0;
        end else begin
            if (s1_adv) vld_q[1] <= vld_pipe[0];
            if (s1_adv && vld_pipe[0]) g_q <= g_comb;
            if (s2_adv) vld_q[2] <= vld_pipe[1];
            if (s2_adv && vld_pipe[1]) begin
                product <= prod_next;
                ovf     <= sum[SUM_W-1];
            end
        end
    end

    assign out_valid = vld_pipe[2];
endmodule

// File: tb/tb_ha_array_accum.sv
// Scoreboard bench for ha_array_accum: per-bit weight model, flow control and reset checks.
module tb_ha_array_accum;
    logic            clk = 0;
    logic            rst = 1;
    logic            in_valid = 0;
    logic            in_ready;
    logic [3:0][6:0] bin = '0;
    logic [3:0][8:0] tin = '0;
    logic            out_valid;
    logic            out_ready = 0;
    logic [15:0]     product;
    logic            ovf;

    int n_pass = 0;
    int n_total = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    ha_array_accum dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ha_array_0_b(bin[0]), .ha_array_1_b(bin[1]),
        .ha_array_2_b(bin[2]), .ha_array_3_b(bin[3]),
        .ha_array_0_t(tin[0]), .ha_array_1_t(tin[1]),
        .ha_array_2_t(tin[2]), .ha_array_3_t(tin[3]),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .ovf(ovf)
    );

    // Reference: every bit carries its own weight (t: 2k+i, b: 2k+i+2).
    function automatic logic [16:0] model(input logic [3:0][8:0] tv, input logic [3:0][6:0] bv);
        logic [16:0] s = '0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 9; i++) if (tv[k][i]) s = s + (17'd1 << (2 * k + i));
            for (int i = 0; i < 7; i++) if (bv[k][i]) s = s + (17'd1 << (2 * k + i + 2));
        end
        return s;
    endfunction

    function automatic logic [15:0] exp_prod(input logic [16:0] s);
`ifdef HA_ARRAY_ACCUM_SAT_EN
        return s[16] ? 16'hFFFF : s[15:0];
`else
        return s[15:0];
`endif
    endfunction

    // One clock: drive at negedge, sample #1 later; pushes the expected sum on accept.
    task automatic cycle(input logic iv, input logic ordy, input logic [3:0][8:0] tv,
                         input logic [3:0][6:0] bv, output logic acc, output logic hs,
                         output logic [15:0] p, output logic o);
        @(negedge clk);
        in_valid = iv; out_ready = ordy; tin = tv; bin = bv;
        #1;
        acc = iv && in_ready;
        hs  = out_valid && out_ready;
        p   = product;
        o   = ovf;
        if (acc) exp_q.push_back(model(tv, bv));
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (product !== 16'h0) $display("FAIL reset_product got=%h exp=0000", product); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
        @(negedge clk); rst = 0;
    endtask

    task automatic test_zero_latency();
        logic acc, hs, o; logic [15:0] p; logic [16:0] e;
        cycle(1, 1, '0, '0, acc, hs, p, o);
        n_total++; if (acc !== 1'b1) $display("FAIL zero_accept got=%b exp=1", acc); else n_pass++;
        cycle(0, 1, '0, '0, acc, hs, p, o);
        n_total++; if (hs !== 1'b0) $display("FAIL zero_lat1 out_valid got=%b exp=0", hs); else n_pass++;
        cycle(0, 1, '0, '0, acc, hs, p, o);
        n_total++; if (hs !== 1'b1) $display("FAIL zero_lat2 out_valid got=%b exp=1", hs); else n_pass++;
        if (hs && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++; if (p !== exp_prod(e) || o !== e[16]) $display("FAIL zero_value got=%h/%b exp=%h/%b", p, o, exp_prod(e), e[16]); else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_single_bits();
        logic acc, hs, o, got; logic [15:0] p; logic [16:0] e;
        logic [3:0][8:0] tv; logic [3:0][6:0] bv;
        logic [15:0] want [4];
        want[0] = 16'h0001; want[1] = 16'h0400; want[2] = 16'h4000; want[3] = 16'h0040;
        for (int n = 0; n < 4; n++) begin
            tv = '0; bv = '0;
            case (n)
                0: tv[0] = 9'h001;
                1: tv[1] = 9'h100;
                2: bv[3] = 7'h40;
                default: bv[2] = 7'h01;
            endcase
            cycle(1, 1, tv, bv, acc, hs, p, o);
            got = 0;
            for (int c = 0; c < 8 && !got; c++) begin
                cycle(0, 1, '0, '0, acc, hs, p, o);
                if (hs) begin
                    got = 1;
                    e = exp_q.pop_front();
                    n_total++; if (p !== want[n] || o !== e[16]) $display("FAIL single_bit%0d got=%h/%b exp=%h/%b", n, p, o, want[n], e[16]); else n_pass++;
                end
            end
            if (!got) begin n_total++; $display("FAIL single_bit%0d_timeout got=none exp=out_valid", n); end
        end
    endtask

    task automatic test_overflow();
        logic acc, hs, o, got; logic [15:0] p; logic [16:0] e;
        logic [3:0][8:0] tv; logic [3:0][6:0] bv;
        logic [15:0] want;
`ifdef HA_ARRAY_ACCUM_SAT_EN
        want = 16'hFFFF;
`else
        want = 16'h5257;
`endif
        tv = {4{9'h1FF}}; bv = {4{7'h7F}};
        cycle(1, 1, tv, bv, acc, hs, p, o);
        got = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            cycle(0, 1, '0, '0, acc, hs, p, o);
            if (hs) begin
                got = 1;
                e = exp_q.pop_front();
                n_total++; if (p !== want || p !== exp_prod(e)) $display("FAIL ovf_product got=%h exp=%h", p, want); else n_pass++;
                n_total++; if (o !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", o); else n_pass++;
            end
        end
        if (!got) begin n_total++; $display("FAIL ovf_timeout got=none exp=out_valid"); end
    endtask

    task automatic test_backpressure();
        logic acc, hs, o; logic [15:0] p; logic [16:0] e;
        logic [3:0][8:0] tv;
        int sent = 0, nrecv = 0, dup = 0;
        for (int c = 0; c < 3; c++) begin
            tv = '0; tv[0] = 9'(sent + 1);
            cycle(1, 0, tv, '0, acc, hs, p, o);
            if (acc) sent++;
        end
        n_total++; if (sent !== 2) $display("FAIL bp_accepts got=%0d exp=2", sent); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tv = '0; tv[0] = 9'(sent + 1);
            cycle(1, 0, tv, '0, acc, hs, p, o);
            if (acc) sent++;
            n_total++; if (out_valid !== 1'b1 || p !== 16'h0001) $display("FAIL bp_hold%0d got=%b/%h exp=1/0001", c, out_valid, p); else n_pass++;
        end
        for (int c = 0; c < 12 && (nrecv < 3 || sent < 3); c++) begin
            tv = '0; tv[0] = 9'(sent + 1);
            cycle(sent < 3, 1, tv, '0, acc, hs, p, o);
            if (acc) sent++;
            if (hs) begin
                e = exp_q.pop_front();
                n_total++; if (p !== 16'(nrecv + 1) || p !== exp_prod(e)) $display("FAIL bp_order%0d got=%h exp=%h", nrecv, p, 16'(nrecv + 1)); else n_pass++;
                nrecv++;
            end
        end
        for (int c = 0; c < 3; c++) begin
            cycle(0, 1, '0, '0, acc, hs, p, o);
            if (hs) dup++;
        end
        n_total++; if (nrecv !== 3 || dup !== 0 || sent !== 3) $display("FAIL bp_count got=%0d+%0d exp=3+0", nrecv, dup); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic acc, hs, o; logic [15:0] p; logic [16:0] e;
        logic [3:0][8:0] tv; logic [3:0][6:0] bv;
        int sent = 0, nrecv = 0, first = -1, last = -1;
        for (int c = 0; c < 14; c++) begin
            for (int k = 0; k < 4; k++) begin
                tv[k] = 9'($urandom_range(0, 511));
                bv[k] = 7'($urandom_range(0, 127));
            end
            cycle(sent < 8, 1, tv, bv, acc, hs, p, o);
            if (acc) sent++;
            if (hs) begin
                if (first < 0) first = c;
                last = c;
                e = exp_q.pop_front();
                n_total++; if (p !== exp_prod(e) || o !== e[16]) $display("FAIL b2b_beat%0d got=%h/%b exp=%h/%b", nrecv, p, o, exp_prod(e), e[16]); else n_pass++;
                nrecv++;
            end
        end
        n_total++; if (nrecv !== 8 || last - first !== 7) $display("FAIL b2b_throughput got=%0d beats over %0d cycles exp=8 over 8", nrecv, last - first + 1); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic acc, hs, o; logic [15:0] p; logic [16:0] e;
        logic [3:0][8:0] tv;
        tv = '0; tv[0] = 9'h055; tv[2] = 9'h0AA;
        repeat (3) cycle(1, 0, tv, '0, acc, hs, p, o);
        n_total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL rstmid_full got=%b/%b exp=1/0", out_valid, in_ready); else n_pass++;
        @(negedge clk); rst = 1; in_valid = 0; out_ready = 1;
        @(negedge clk); rst = 0;
        #1;
        exp_q.delete();
        n_total++; if (out_valid !== 1'b0 || product !== 16'h0 || in_ready !== 1'b1) $display("FAIL rstmid_clear got=%b/%h/%b exp=0/0000/1", out_valid, product, in_ready); else n_pass++;
        tv = '0; tv[1] = 9'h003;
        cycle(1, 1, tv, '0, acc, hs, p, o);
        cycle(0, 1, '0, '0, acc, hs, p, o);
        n_total++; if (hs !== 1'b0) $display("FAIL rstmid_lat1 got=%b exp=0", hs); else n_pass++;
        cycle(0, 1, '0, '0, acc, hs, p, o);
        if (hs && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++; if (p !== 16'h000C || p !== exp_prod(e)) $display("FAIL rstmid_value got=%h exp=000c", p); else n_pass++;
        end else begin
            n_total++; $display("FAIL rstmid_lat2 got=%b exp=1", hs);
        end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_single_bits();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
